alu_op_sequencer: RTL and testbench

Microsequencer that drives the mini CPU data_path control strobes for one register-level command at a time. It takes the place of hand-written per-state stimulus.
- Accepts a command over a valid/ready handshake.
- Steps through the T-states for that command: MDR load, Y load, ALU execute into Z, Z writeback.
- Emits the matching one-hot register enables, MDR/Y/Z/HI/LO strobes and ALU op code, then pulses done.

---
 rtl/alu_op_sequencer.sv | 176 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: walks one register-level command through its T-states and
// drives the matching data_path strobes, register enables and ALU op code.
module alu_op_sequencer #(
    parameter int NREGS  = 16,
    parameter int REG_W  = 4,
    parameter int OP_W   = 5,
    parameter int DATA_W = 32
) (
    input  logic              Clock,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_cmd,
    input  logic [OP_W-1:0]   req_op,
    input  logic [REG_W-1:0]  req_ra,
    input  logic [REG_W-1:0]  req_rb,
    input  logic [REG_W-1:0]  req_rc,
    input  logic [DATA_W-1:0] req_imm,
    output logic [NREGS-1:0]  Rout,
    output logic [NREGS-1:0]  Rin,
    output logic              Read,
    output logic              MDRin,
    output logic              MDRout,
    output logic [DATA_W-1:0] Mdatain,
    output logic              Yin,
    output logic              Zlowin,
    output logic              ZHighin,
    output logic              Zlowout,
    output logic              ZHighout,
    output logic              LOin,
    output logic              HIin,
    output logic [OP_W-1:0]   op,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] CMD_BINARY = 2'd0;
    localparam logic [1:0] CMD_UNARY  = 2'd1;
    localparam logic [1:0] CMD_LDIMM  = 2'd2;
    localparam logic [1:0] CMD_MULDIV = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_MDR = 3'd1,
        S_MDR_WB = 3'd2,
        S_Y_LOAD = 3'd3,
        S_EXEC   = 3'd4,
        S_ZLO_WB = 3'd5,
        S_ZHI_WB = 3'd6
    } state_t;

    state_t state, state_n;

    // Command fields captured at acceptance and held for the whole command.
    logic [1:0]        cmd_p0;
    logic [OP_W-1:0]   op_p0;
    logic [REG_W-1:0]  ra_p0;
    logic [REG_W-1:0]  rb_p0;
    logic [REG_W-1:0]  rc_p0;
    logic [DATA_W-1:0] imm_p0;

    logic accept;

    function automatic logic [NREGS-1:0] onehot(input logic [REG_W-1:0] idx);
        onehot = {{(NREGS-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign req_ready = (state == S_IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid && req_ready;
    assign Mdatain   = imm_p0;

    // State register; clear aborts any command in flight.
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) state <= S_IDLE;
        else       state <= state_n;
    end

    // Latch the request fields on acceptance only; ignored while busy.
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            cmd_p0 <= '0;
            op_p0  <= '0;
            ra_p0  <= '0;
            rb_p0  <= '0;
            rc_p0  <= '0;
            imm_p0 <= '0;
        end else if (accept) begin
            cmd_p0 <= req_cmd;
            op_p0  <= req_op;
            ra_p0  <= req_ra;
            rb_p0  <= req_rb;
            rc_p0  <= req_rc;
            imm_p0 <= req_imm;
        end
    end

    // Next-state: the entry state depends on the incoming command, later
    // steps on the latched one.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    case (req_cmd)
                        CMD_UNARY: state_n = S_EXEC;
                        CMD_LDIMM: state_n = S_LD_MDR;
                        default:   state_n = S_Y_LOAD;
                    endcase
                end
            end
            S_LD_MDR: state_n = S_MDR_WB;
            S_MDR_WB: state_n = S_IDLE;
            S_Y_LOAD: state_n = S_EXEC;
            S_EXEC:   state_n = S_ZLO_WB;
            S_ZLO_WB: state_n = (cmd_p0 == CMD_MULDIV) ? S_ZHI_WB : S_IDLE;
            S_ZHI_WB: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    // Moore strobe decode from the state and latched fields.
    always_comb begin
        Rout     = '0;
        Rin      = '0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Yin      = 1'b0;
        Zlowin   = 1'b0;
        ZHighin  = 1'b0;
        Zlowout  = 1'b0;
        ZHighout = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        op       = '0;
        done     = 1'b0;
        case (state)
            S_LD_MDR: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_MDR_WB: begin
                MDRout = 1'b1;
                Rin    = onehot(ra_p0);
                done   = 1'b1;
            end
            S_Y_LOAD: begin
                Rout = onehot(rb_p0);
                Yin  = 1'b1;
            end
            S_EXEC: begin
                Rout    = (cmd_p0 == CMD_UNARY) ? onehot(rb_p0) : onehot(rc_p0);
                Zlowin  = 1'b1;
                ZHighin = (cmd_p0 == CMD_MULDIV);
                op      = op_p0;
            end
            S_ZLO_WB: begin
                Zlowout = 1'b1;
                if (cmd_p0 == CMD_MULDIV) begin
                    LOin = 1'b1;
                end else begin
                    Rin  = onehot(ra_p0);
                    done = 1'b1;
                end
            end
            S_ZHI_WB: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: directed test-plan commands, back-to-back
// hold, mid-command clear and randomized commands against a schedule model.
module tb_alu_op_sequencer;

    localparam int NREGS  = 16;
    localparam int REG_W  = 4;
    localparam int OP_W   = 5;
    localparam int DATA_W = 32;

    localparam logic [9:0] F_READ  = 10'h200;
    localparam logic [9:0] F_MDRIN = 10'h100;
    localparam logic [9:0] F_MDROUT= 10'h080;
    localparam logic [9:0] F_YIN   = 10'h040;
    localparam logic [9:0] F_ZLIN  = 10'h020;
    localparam logic [9:0] F_ZHIN  = 10'h010;
    localparam logic [9:0] F_ZLOUT = 10'h008;
    localparam logic [9:0] F_ZHOUT = 10'h004;
    localparam logic [9:0] F_LOIN  = 10'h002;
    localparam logic [9:0] F_HIIN  = 10'h001;

    logic              Clock;
    logic              clear;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_cmd;
    logic [OP_W-1:0]   req_op;
    logic [REG_W-1:0]  req_ra, req_rb, req_rc;
    logic [DATA_W-1:0] req_imm;
    logic [NREGS-1:0]  Rout, Rin;
    logic              Read, MDRin, MDRout;
    logic [DATA_W-1:0] Mdatain;
    logic              Yin, Zlowin, ZHighin, Zlowout, ZHighout, LOin, HIin;
    logic [OP_W-1:0]   op;
    logic              busy, done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] exp_imm;
    logic [48:0] exp_q[$];
    logic [48:0] obs_vec;

    alu_op_sequencer #(.NREGS(NREGS), .REG_W(REG_W), .OP_W(OP_W), .DATA_W(DATA_W)) dut (
        .Clock(Clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_op(req_op), .req_ra(req_ra), .req_rb(req_rb),
        .req_rc(req_rc), .req_imm(req_imm), .Rout(Rout), .Rin(Rin), .Read(Read),
        .MDRin(MDRin), .MDRout(MDRout), .Mdatain(Mdatain), .Yin(Yin),
        .Zlowin(Zlowin), .ZHighin(ZHighin), .Zlowout(Zlowout), .ZHighout(ZHighout),
        .LOin(LOin), .HIin(HIin), .op(op), .busy(busy), .done(done)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    assign obs_vec = {Rout, Rin, Read, MDRin, MDRout, Yin, Zlowin, ZHighin,
                      Zlowout, ZHighout, LOin, HIin, op, done, req_ready};

    function automatic logic [15:0] oh(input logic [3:0] i);
        logic [15:0] one;
        one = 16'h0001;
        return one << i;
    endfunction

    function automatic logic [48:0] mk(input logic [15:0] ro, input logic [15:0] ri,
                                       input logic [9:0] fl, input logic [4:0] o,
                                       input logic dn, input logic rdy);
        return {ro, ri, fl, o, dn, rdy};
    endfunction

    // Expected per-cycle outputs of a command, from the T-state schedule.
    task automatic build_expect(input logic [1:0] c, input logic [4:0] o,
                                input logic [3:0] a, input logic [3:0] b, input logic [3:0] cc);
        exp_q.delete();
        case (c)
            2'd0: begin
                exp_q.push_back(mk(oh(b), 16'h0, F_YIN, 5'd0, 1'b0, 1'b0));
                exp_q.push_back(mk(oh(cc), 16'h0, F_ZLIN, o, 1'b0, 1'b0));
                exp_q.push_back(mk(16'h0, oh(a), F_ZLOUT, 5'd0, 1'b1, 1'b0));
            end
            2'd1: begin
                exp_q.push_back(mk(oh(b), 16'h0, F_ZLIN, o, 1'b0, 1'b0));
                exp_q.push_back(mk(16'h0, oh(a), F_ZLOUT, 5'd0, 1'b1, 1'b0));
            end
            2'd2: begin
                exp_q.push_back(mk(16'h0, 16'h0, F_READ | F_MDRIN, 5'd0, 1'b0, 1'b0));
                exp_q.push_back(mk(16'h0, oh(a), F_MDROUT, 5'd0, 1'b1, 1'b0));
            end
            default: begin
                exp_q.push_back(mk(oh(b), 16'h0, F_YIN, 5'd0, 1'b0, 1'b0));
                exp_q.push_back(mk(oh(cc), 16'h0, F_ZLIN | F_ZHIN, o, 1'b0, 1'b0));
                exp_q.push_back(mk(16'h0, 16'h0, F_ZLOUT | F_LOIN, 5'd0, 1'b0, 1'b0));
                exp_q.push_back(mk(16'h0, 16'h0, F_ZHOUT | F_HIIN, 5'd0, 1'b1, 1'b0));
            end
        endcase
    endtask

    task automatic check_step(input string name, input logic [48:0] exp);
        int drivers;
        n_tests++;
        if (obs_vec !== exp) begin
            n_fail++;
            $display("FAIL %s outputs: got %h expected %h", name, obs_vec, exp);
        end
        n_tests++;
        if (Mdatain !== exp_imm) begin
            n_fail++;
            $display("FAIL %s Mdatain: got %h expected %h", name, Mdatain, exp_imm);
        end
        n_tests++;
        if (busy !== ~exp[0]) begin
            n_fail++;
            $display("FAIL %s busy: got %b expected %b", name, busy, ~exp[0]);
        end
        drivers = int'(|Rout) + int'(MDRout) + int'(Zlowout) + int'(ZHighout);
        n_tests++;
        if ($countones(Rout) > 1 || drivers > 1) begin
            n_fail++;
            $display("FAIL %s bus_drivers: got Rout=%h drivers=%0d expected at most one", name, Rout, drivers);
        end
    endtask

    // Wait for idle (bounded), present a command and step past its acceptance edge.
    task automatic start(input logic [1:0] c, input logic [4:0] o, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] cc, input logic [31:0] im);
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) begin
            @(posedge Clock); #1;
        end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_ready: got %b expected 1", req_ready);
        end
        req_valid = 1'b1;
        req_cmd = c; req_op = o; req_ra = a; req_rb = b; req_rc = cc; req_imm = im;
        @(posedge Clock); #1;
        exp_imm = im;
    endtask

    task automatic scramble_inputs();
        req_cmd = 2'($urandom); req_op = 5'($urandom);
        req_ra = 4'($urandom); req_rb = 4'($urandom); req_rc = 4'($urandom);
        req_imm = $urandom;
    endtask

    // Check every busy cycle of the accepted command, then the idle cycle after done.
    task automatic check_cmd(input string name, input logic [1:0] c, input logic [4:0] o,
                             input logic [3:0] a, input logic [3:0] b, input logic [3:0] cc);
        build_expect(c, o, a, b, cc);
        for (int i = 0; i < exp_q.size(); i++) begin
            check_step($sformatf("%s[%0d]", name, i), exp_q[i]);
            @(posedge Clock); #1;
        end
        check_step($sformatf("%s_idle", name), mk(16'h0, 16'h0, 10'h0, 5'd0, 1'b0, 1'b1));
    endtask

    task automatic run_cmd(input string name, input logic [1:0] c, input logic [4:0] o,
                           input logic [3:0] a, input logic [3:0] b, input logic [3:0] cc,
                           input logic [31:0] im);
        start(c, o, a, b, cc, im);
        req_valid = 1'b0;
        scramble_inputs();
        check_cmd(name, c, o, a, b, cc);
    endtask

    task automatic test_reset();
        clear = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        exp_imm = '0;
        check_step("reset", mk(16'h0, 16'h0, 10'h0, 5'd0, 1'b0, 1'b1));
        clear = 1'b0;
        @(posedge Clock); #1;
        check_step("reset_release", mk(16'h0, 16'h0, 10'h0, 5'd0, 1'b0, 1'b1));
    endtask

    task automatic test_directed();
        run_cmd("ldimm", 2'd2, 5'd0, 4'd7, 4'd0, 4'd0, 32'd12);
        run_cmd("unary", 2'd1, 5'b01001, 4'd6, 4'd7, 4'd0, 32'd0);
        run_cmd("binary", 2'd0, 5'b00011, 4'd3, 4'd1, 4'd2, 32'hDEAD0001);
        run_cmd("muldiv", 2'd3, 5'b01110, 4'd9, 4'd4, 4'd5, 32'h0000_0055);
        run_cmd("edge_r0", 2'd0, 5'b10101, 4'd0, 4'd0, 4'd0, 32'hFFFF_FFFF);
        run_cmd("edge_r15", 2'd1, 5'b11111, 4'd15, 4'd15, 4'd3, 32'h8000_0000);
    endtask

    task automatic test_back_to_back();
        start(2'd3, 5'd2, 4'd1, 4'd10, 4'd11, 32'hAAAA_0001);
        req_valid = 1'b1;
        req_cmd = 2'd2; req_op = 5'd7; req_ra = 4'd12; req_rb = 4'd1; req_rc = 4'd2;
        req_imm = 32'h5555_0002;
        check_cmd("b2b_first", 2'd3, 5'd2, 4'd1, 4'd10, 4'd11);
        @(posedge Clock); #1;
        exp_imm = 32'h5555_0002;
        req_valid = 1'b0;
        scramble_inputs();
        check_cmd("b2b_second", 2'd2, 5'd7, 4'd12, 4'd1, 4'd2);
    endtask

    task automatic test_clear_mid();
        start(2'd0, 5'd3, 4'd9, 4'd1, 4'd2, 32'h1234_5678);
        req_valid = 1'b0;
        build_expect(2'd0, 5'd3, 4'd9, 4'd1, 4'd2);
        check_step("clr_yload", exp_q[0]);
        @(posedge Clock); #1;
        check_step("clr_exec", exp_q[1]);
        #2 clear = 1'b1;
        #1;
        exp_imm = '0;
        check_step("clr_async", mk(16'h0, 16'h0, 10'h0, 5'd0, 1'b0, 1'b1));
        @(posedge Clock); #1;
        check_step("clr_held", mk(16'h0, 16'h0, 10'h0, 5'd0, 1'b0, 1'b1));
        #2 clear = 1'b0;
        @(posedge Clock); #1;
        check_step("clr_after", mk(16'h0, 16'h0, 10'h0, 5'd0, 1'b0, 1'b1));
        run_cmd("clr_next", 2'd0, 5'd4, 4'd5, 4'd6, 4'd7, 32'h0BAD_F00D);
    endtask

    task automatic test_random();
        logic [1:0] c;
        logic [4:0] o;
        logic [3:0] a, b, cc;
        logic [31:0] im;
        for (int n = 0; n < 40; n++) begin
            c = 2'($urandom_range(0, 3));
            o = 5'($urandom);
            a = 4'($urandom);
            b = 4'($urandom);
            cc = ($urandom_range(0, 3) == 0) ? b : 4'($urandom);
            if ($urandom_range(0, 4) == 0) a = 4'd0;
            im = $urandom;
            run_cmd($sformatf("rand%0d", n), c, o, a, b, cc, im);
            repeat ($urandom_range(0, 2)) begin
                @(posedge Clock); #1;
            end
        end
    endtask

    initial begin
        clear = 1'b1;
        req_valid = 1'b0;
        req_cmd = '0; req_op = '0; req_ra = '0; req_rb = '0; req_rc = '0; req_imm = '0;
        exp_imm = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_clear_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
